fetch_ctrl: RTL

//  Fetch sequencer between ins_mem and decode in the riscv32i core.

---
 rtl/fetch_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencer for the riscv32i core: owns the PC, issues word fetches on a
// grant-based instruction port and feeds decode from a 2-entry FIFO.
module fetch_ctrl #(
    parameter int                 N_param  = 32,
    parameter logic [N_param-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_o,
    output logic [N_param-1:0] imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic [N_param-1:0] imem_rdata_i,
    input  logic               redirect_i,
    input  logic [N_param-1:0] redirect_pc_i,
    output logic               inst_valid_o,
    output logic [N_param-1:0] inst_o,
    output logic [N_param-1:0] inst_pc_o,
    input  logic               dec_ready_i,
    output logic               misalign_o
);
    localparam int DEPTH = 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state_reg;
    logic [N_param-1:0] pc_reg;
    logic [N_param-1:0] pend_pc_reg;
    logic               pending_reg;
    logic               misalign_reg;
    logic [1:0]         count_reg;
    logic [1:0]         count_next;
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;

    logic [N_param-1:0] inst_mem [DEPTH];
    logic [N_param-1:0] pc_mem   [DEPTH];

    logic               pop;
    logic               push;
    logic               accept;
    logic               flush;
    logic               bad_target;
    logic [2:0]         credit;

    // Credit counts buffered entries plus the one in flight, minus what decode
    // takes this cycle, so a granted fetch always has a free slot to land in.
    always_comb begin
        pop        = (count_reg != 2'd0) && dec_ready_i;
        push       = pending_reg && !redirect_i;
        credit     = {1'b0, count_reg} + {2'b00, pending_reg} - {2'b00, pop};
        imem_req_o = (state_reg == RUN) && !redirect_i && (credit < 3'd2);
        accept     = imem_req_o && imem_gnt_i;
        flush      = redirect_i && (state_reg != HALT);
        bad_target = (redirect_pc_i[1:0] != 2'b00);
        count_next = count_reg + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC;
            pending_reg  <= 1'b0;
            pend_pc_reg  <= '0;
            misalign_reg <= 1'b0;
        end else begin
            pending_reg <= accept;
            if (accept) begin
                pend_pc_reg <= pc_reg;
                pc_reg      <= pc_reg + N_param'(4);
            end
            case (state_reg)
                BOOT:    state_reg <= RUN;
                RUN:     state_reg <= RUN;
                HALT:    state_reg <= HALT;
                default: state_reg <= BOOT;
            endcase
            // A redirect never coincides with a grant, so it simply takes the PC.
            if (flush) begin
                pc_reg <= redirect_pc_i;
                if (bad_target) begin
                    state_reg    <= HALT;
                    misalign_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && (count_reg == 2'd2)));
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [N_param-1:0] inst_reg;
        logic [N_param-1:0] epc_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                inst_reg <= '0;
                epc_reg  <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                inst_reg <= imem_rdata_i;
                epc_reg  <= pend_pc_reg;
            end
        end

        assign inst_mem[gi] = inst_reg;
        assign pc_mem[gi]   = epc_reg;
    end

    assign imem_addr_o  = pc_reg;
    assign inst_valid_o = (count_reg != 2'd0);
    assign inst_o       = inst_mem[rd_ptr_reg];
    assign inst_pc_o    = pc_mem[rd_ptr_reg];
    assign misalign_o   = misalign_reg;

endmodule
